column_mux_scheduler: RTL

// Drives the LED-column multiplexing lines (gpio_0 mux outputs) in lock-step with driver_controller.
// - column_ready from driver_controller opens a dead-time gap, then the next column is enabled one-hot.
// - position_sync rising edges realign the sequence to column 0.
// - A watchdog blanks all columns if driver_controller stalls, so no column is left lit indefinitely.
//

---
 rtl/spirose_mux_pkg.sv | 17 +
 rtl/sync_edge_detect.sv | 31 +++
 rtl/column_mux_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/spirose_mux_pkg.sv
// Shared types and defaults for the LED-column multiplexing scheduler.
package spirose_mux_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SYNC,
    WAIT_COL,
    DEAD,
    ON,
    FAULT
  } mux_state_t;

  localparam int NB_COLUMNS_DEFAULT      = 8;
  localparam int DEAD_TIME_DEFAULT       = 16;
  localparam int WATCHDOG_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous pin plus a registered rising-edge pulse.
module sync_edge_detect (
  input  logic clock_66,
  input  logic nrst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;

  // The pulse is registered, so it appears three edges after the pin rises.
  always_ff @(posedge clock_66 or negedge nrst) begin
    if (!nrst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/column_mux_scheduler.sv
// One-hot LED column enable sequencer: dead-time gaps between columns, sync realignment
// to column 0, and a watchdog that blanks the columns if the driver stops handshaking.
module column_mux_scheduler
  import spirose_mux_pkg::*;
#(
  parameter int NB_COLUMNS      = NB_COLUMNS_DEFAULT,
  parameter int DEAD_TIME       = DEAD_TIME_DEFAULT,
  parameter int WATCHDOG_CYCLES = WATCHDOG_CYCLES_DEFAULT
) (
  input  logic                          clock_66,
  input  logic                          nrst,
  input  logic                          i_enable,
  input  logic                          i_position_sync,
  input  logic                          i_column_ready,
  output logic [NB_COLUMNS-1:0]         o_mux_out,
  output logic [$clog2(NB_COLUMNS)-1:0] o_column_index,
  output logic                          o_frame_start,
  output logic                          o_fault
);

  localparam int IDX_W = $clog2(NB_COLUMNS);
  localparam int DC_W  = $clog2(DEAD_TIME + 1);
  localparam int WD_W  = $clog2(WATCHDOG_CYCLES + 1);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NB_COLUMNS - 1);
  localparam logic [DC_W-1:0]  DEAD_LOAD = DC_W'(DEAD_TIME - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(WATCHDOG_CYCLES - 1);

  mux_state_t             r_state;
  logic [IDX_W-1:0]       r_column_index;
  logic                   r_restart_pending;
  logic [DC_W-1:0]        r_dead_cnt;
  logic [WD_W-1:0]        r_wd_cnt;
  logic [NB_COLUMNS-1:0]  r_mux_out;
  logic                   r_frame_start;
  logic                   r_fault;

  mux_state_t             w_state_next;
  logic [IDX_W-1:0]       w_index_next;
  logic                   w_restart_next;
  logic [DC_W-1:0]        w_dead_next;
  logic [WD_W-1:0]        w_wd_next;
  logic [NB_COLUMNS-1:0]  w_mux_next;
  logic                   w_frame_next;
  logic                   w_fault_next;
  logic                   w_sync_edge;
  logic [IDX_W-1:0]       w_index_wrap;

  sync_edge_detect u_sync (
    .clock_66 (clock_66),
    .nrst     (nrst),
    .i_async  (i_position_sync),
    .o_rise   (w_sync_edge)
  );

  assign w_index_wrap = (r_column_index == IDX_LAST) ? '0 : r_column_index + 1'b1;

  always_comb begin
    w_state_next   = r_state;
    w_index_next   = r_column_index;
    w_restart_next = r_restart_pending;
    w_dead_next    = r_dead_cnt;
    w_wd_next      = '0;
    w_frame_next   = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_enable) w_state_next = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (w_sync_edge) begin
          w_state_next   = WAIT_COL;
          w_index_next   = '0;
          w_restart_next = 1'b1;
        end
      end
      WAIT_COL: begin
        w_wd_next = r_wd_cnt + 1'b1;
        if (w_sync_edge) w_restart_next = 1'b1;
        if (i_column_ready) begin
          w_state_next = DEAD;
          w_dead_next  = DEAD_LOAD;
          w_wd_next    = '0;
        end else if (r_wd_cnt == WD_LAST) begin
          w_state_next = FAULT;
        end
      end
      DEAD: begin
        // column_ready is deliberately ignored here: it neither shortens the gap nor feeds the watchdog
        w_wd_next = r_wd_cnt + 1'b1;
        if (w_sync_edge) w_restart_next = 1'b1;
        if (r_wd_cnt == WD_LAST) begin
          w_state_next = FAULT;
        end else if (r_dead_cnt == '0) begin
          w_state_next = ON;
          if (r_restart_pending || w_sync_edge) begin
            w_index_next   = '0;
            w_frame_next   = 1'b1;
            w_restart_next = 1'b0;
          end else begin
            w_index_next = w_index_wrap;
          end
        end else begin
          w_dead_next = r_dead_cnt - 1'b1;
        end
      end
      ON: begin
        w_wd_next = r_wd_cnt + 1'b1;
        if (w_sync_edge) w_restart_next = 1'b1;
        if (i_column_ready) begin
          w_state_next = DEAD;
          w_dead_next  = DEAD_LOAD;
          w_wd_next    = '0;
        end else if (r_wd_cnt == WD_LAST) begin
          w_state_next = FAULT;
        end
      end
      FAULT: begin
        w_state_next = FAULT;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (!i_enable) begin
      w_state_next   = IDLE;
      w_index_next   = '0;
      w_restart_next = 1'b0;
      w_dead_next    = '0;
      w_wd_next      = '0;
      w_frame_next   = 1'b0;
    end

    // Outputs follow the next state so mux_out is a clean register, never a decoded glitch
    w_mux_next   = (w_state_next == ON) ? (NB_COLUMNS'(1) << w_index_next) : '0;
    w_fault_next = (w_state_next == FAULT);
  end

  always_ff @(posedge clock_66 or negedge nrst) begin
    if (!nrst) begin
      r_state           <= IDLE;
      r_column_index    <= '0;
      r_restart_pending <= 1'b0;
      r_dead_cnt        <= '0;
      r_wd_cnt          <= '0;
      r_mux_out         <= '0;
      r_frame_start     <= 1'b0;
      r_fault           <= 1'b0;
    end else begin
      r_state           <= w_state_next;
      r_column_index    <= w_index_next;
      r_restart_pending <= w_restart_next;
      r_dead_cnt        <= w_dead_next;
      r_wd_cnt          <= w_wd_next;
      r_mux_out         <= w_mux_next;
      r_frame_start     <= w_frame_next;
      r_fault           <= w_fault_next;
    end
  end

  assign o_mux_out      = r_mux_out;
  assign o_column_index = r_column_index;
  assign o_frame_start  = r_frame_start;
  assign o_fault        = r_fault;

endmodule
